ifu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the ifu fetch unit. It walks each instruction through

---
 rtl/ifu_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ifu_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ifu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ifu fetch unit.
// Advances the PC exactly once per instruction and halts on illegal opcodes or memory timeouts.

`ifndef IFU_SEL_NORM
`define IFU_SEL_NORM       2'd0
`endif
`ifndef IFU_SEL_RELATIVE
`define IFU_SEL_RELATIVE   2'd1
`endif
`ifndef IFU_SEL_IRRELATIVE
`define IFU_SEL_IRRELATIVE 2'd2
`endif
`ifndef IFU_SEL_REGISTER
`define IFU_SEL_REGISTER   2'd3
`endif

// state  | meaning
// FETCH  | latch next instruction (imNextEn)
// DECODE | classify opcode/funct, trap illegal
// EXEC   | branch/jump resolve or dispatch to MEM/WB
// MEM    | wait for data memory, bounded by MEM_TIMEOUT
// WB     | register write and PC advance
// HALT   | fault parked until reset
module ifu_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       npc_sel,
    output logic             pcWriteEn,
    output logic             imNextEn,
    output logic             regWriteEn,
    output logic             memWriteEn,
    output logic             exc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    // ALU R-type, ORI and LUI share one path: EXEC -> WB
    typedef enum logic [2:0] {
        C_REG, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL
    } cls_t;

    state_t             state_q, state_d;
    cls_t               cls_q, cls_d, dec_cls;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               exc_q, exc_d;
    logic [CNT_W-1:0]   retired_q;

    always_comb begin
        dec_cls = C_ILL;
        case (opcode)
            6'h00: begin
                if (funct == 6'h21 || funct == 6'h23) dec_cls = C_REG;
                else if (funct == 6'h08)              dec_cls = C_JR;
            end
            6'h0d, 6'h0f: dec_cls = C_REG;
            6'h23:        dec_cls = C_LW;
            6'h2b:        dec_cls = C_SW;
            6'h04:        dec_cls = C_BEQ;
            6'h02:        dec_cls = C_J;
            6'h03:        dec_cls = C_JAL;
            default:      dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            wait_q    <= '0;
            exc_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            exc_q     <= exc_d;
            retired_q <= retired_q + CNT_W'(pcWriteEn);
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        wait_d     = wait_q;
        exc_d      = exc_q;
        imNextEn   = 1'b0;
        pcWriteEn  = 1'b0;
        regWriteEn = 1'b0;
        memWriteEn = 1'b0;
        npc_sel    = `IFU_SEL_NORM;
        case (state_q)
            S_FETCH: begin
                imNextEn = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_ILL) begin
                    state_d = S_HALT;
                    exc_d   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_REG: state_d = S_WB;
                    C_LW, C_SW: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    C_BEQ: begin
                        pcWriteEn = 1'b1;
                        npc_sel   = zero ? `IFU_SEL_RELATIVE : `IFU_SEL_NORM;
                        state_d   = S_FETCH;
                    end
                    C_J, C_JAL: begin
                        pcWriteEn  = 1'b1;
                        regWriteEn = (cls_q == C_JAL);
                        npc_sel    = `IFU_SEL_IRRELATIVE;
                        state_d    = S_FETCH;
                    end
                    C_JR: begin
                        pcWriteEn = 1'b1;
                        npc_sel   = `IFU_SEL_REGISTER;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        state_d = S_HALT;
                        exc_d   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                memWriteEn = (cls_q == C_SW);
                // mem_ready takes priority over a timeout landing in the same cycle
                if (mem_ready) begin
                    if (cls_q == C_SW) begin
                        pcWriteEn = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    exc_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                regWriteEn = 1'b1;
                pcWriteEn  = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: exc_d = 1'b1;
            default: begin
                state_d = S_HALT;
                exc_d   = 1'b1;
            end
        endcase
        if (reset) begin
            imNextEn   = 1'b0;
            pcWriteEn  = 1'b0;
            regWriteEn = 1'b0;
            memWriteEn = 1'b0;
            npc_sel    = `IFU_SEL_NORM;
        end
    end

    assign state   = state_q;
    assign exc     = exc_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_ifu_seq_ctrl.sv
// Directed bench for ifu_seq_ctrl: per-cycle expected outputs go through a scoreboard queue
// and are compared against the DUT one nanosecond after each falling edge.
module tb_ifu_seq_ctrl;

    localparam int CNT_W = 32;
    localparam logic [1:0] NORM = 2'd0, REL = 2'd1, IRR = 2'd2, REGS = 2'd3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       opcode = '0, funct = '0;
    logic             zero = 1'b0, mem_ready = 1'b0;
    logic [1:0]       npc_sel;
    logic             pcWriteEn, imNextEn, regWriteEn, memWriteEn, exc;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    ifu_seq_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .npc_sel(npc_sel), .pcWriteEn(pcWriteEn),
        .imNextEn(imNextEn), .regWriteEn(regWriteEn), .memWriteEn(memWriteEn),
        .exc(exc), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             im, pc, rw, mw;
        logic [1:0]       sel;
        logic             ex;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input logic [2:0] st,
                        input logic im, input logic pc, input logic rw, input logic mw,
                        input logic [1:0] sel, input logic ex);
        exp_t e, o;
        opcode = op; funct = fn; zero = z; mem_ready = mr;
        e.st = st; e.im = im; e.pc = pc; e.rw = rw; e.mw = mw;
        e.sel = sel; e.ex = ex; e.ret = exp_ret;
        sb.push_back(e);
        if (pc && !reset) exp_ret = exp_ret + 1;
        #1;
        o.st = state; o.im = imNextEn; o.pc = pcWriteEn; o.rw = regWriteEn;
        o.mw = memWriteEn; o.sel = npc_sel; o.ex = exc; o.ret = retired;
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed st=%0d im=%b pc=%b rw=%b mw=%b sel=%0d exc=%b ret=%0d expected st=%0d im=%b pc=%b rw=%b mw=%b sel=%0d exc=%b ret=%0d",
                   tag, o.st, o.im, o.pc, o.rw, o.mw, o.sel, o.ex, o.ret,
                   e.st, e.im, e.pc, e.rw, e.mw, e.sel, e.ex, e.ret);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        exp_ret = '0;
        step(tag, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, NORM, 1'b0);
        reset = 1'b0;
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        step({tag, "_fetch"},  op, fn, 1'b0, 1'b0, 3'd0, 1, 0, 0, 0, NORM, 1'b0);
        step({tag, "_decode"}, op, fn, 1'b0, 1'b0, 3'd1, 0, 0, 0, 0, NORM, 1'b0);
    endtask

    task automatic do_reg(input string tag, input logic [5:0] op, input logic [5:0] fn);
        fetch_decode(tag, op, fn);
        step({tag, "_exec"}, op, fn, 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, NORM, 1'b0);
        step({tag, "_wb"},   op, fn, 1'b0, 1'b0, 3'd4, 0, 1, 1, 0, NORM, 1'b0);
    endtask

    task automatic do_jump(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [1:0] sel, input logic rw);
        fetch_decode(tag, op, fn);
        step({tag, "_exec"}, op, fn, z, 1'b0, 3'd2, 0, 1, rw, 0, sel, 1'b0);
    endtask

    task automatic do_mem(input string tag, input logic [5:0] op, input int waits, input logic is_sw);
        fetch_decode(tag, op, 6'h00);
        step({tag, "_exec"}, op, 6'h00, 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, NORM, 1'b0);
        for (int i = 0; i < waits; i++)
            step({tag, "_wait"}, op, 6'h00, 1'b0, 1'b0, 3'd3, 0, 0, 0, is_sw, NORM, 1'b0);
        step({tag, "_ready"}, op, 6'h00, 1'b0, 1'b1, 3'd3, 0, is_sw, 0, is_sw, NORM, 1'b0);
        if (!is_sw)
            step({tag, "_wb"}, op, 6'h00, 1'b0, 1'b0, 3'd4, 0, 1, 1, 0, NORM, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");

        do_reg("addu", 6'h00, 6'h21);
        do_jump("beq_taken", 6'h04, 6'h00, 1'b1, REL, 1'b0);
        do_jump("beq_not",   6'h04, 6'h00, 1'b0, NORM, 1'b0);
        do_reg("subu", 6'h00, 6'h23);
        do_reg("ori",  6'h0d, 6'h00);
        do_reg("lui",  6'h0f, 6'h00);
        do_mem("lw3",  6'h23, 3, 1'b0);
        do_mem("sw2",  6'h2b, 2, 1'b1);
        do_mem("lw15", 6'h23, 15, 1'b0);
        do_jump("jal", 6'h03, 6'h00, 1'b0, IRR, 1'b1);
        do_jump("jr",  6'h00, 6'h08, 1'b0, REGS, 1'b0);
        do_jump("j",   6'h02, 6'h00, 1'b1, IRR, 1'b0);

        step("ill_fetch",  6'h3f, 6'h00, 1'b0, 1'b0, 3'd0, 1, 0, 0, 0, NORM, 1'b0);
        step("ill_decode", 6'h3f, 6'h00, 1'b0, 1'b0, 3'd1, 0, 0, 0, 0, NORM, 1'b0);
        step("ill_halt0",  6'h3f, 6'h00, 1'b1, 1'b1, 3'd7, 0, 0, 0, 0, NORM, 1'b1);
        step("ill_halt1",  6'h23, 6'h00, 1'b1, 1'b1, 3'd7, 0, 0, 0, 0, NORM, 1'b1);
        do_reset("reset_after_ill");

        step("illfn_fetch",  6'h00, 6'h20, 1'b0, 1'b0, 3'd0, 1, 0, 0, 0, NORM, 1'b0);
        step("illfn_decode", 6'h00, 6'h20, 1'b0, 1'b0, 3'd1, 0, 0, 0, 0, NORM, 1'b0);
        step("illfn_halt",   6'h00, 6'h20, 1'b0, 1'b0, 3'd7, 0, 0, 0, 0, NORM, 1'b1);
        do_reset("reset_after_illfn");

        do_reg("addu_pre_to", 6'h00, 6'h21);
        fetch_decode("lw_to", 6'h23, 6'h00);
        step("lw_to_exec", 6'h23, 6'h00, 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, NORM, 1'b0);
        for (int i = 0; i < 16; i++)
            step("lw_to_wait", 6'h23, 6'h00, 1'b0, 1'b0, 3'd3, 0, 0, 0, 0, NORM, 1'b0);
        step("lw_to_halt",  6'h23, 6'h00, 1'b0, 1'b1, 3'd7, 0, 0, 0, 0, NORM, 1'b1);
        do_reset("reset_after_to");

        do_reg("addu_pre_mid", 6'h00, 6'h21);
        fetch_decode("sw_mid", 6'h2b, 6'h00);
        step("sw_mid_exec", 6'h2b, 6'h00, 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, NORM, 1'b0);
        step("sw_mid_wait", 6'h2b, 6'h00, 1'b0, 1'b0, 3'd3, 0, 0, 0, 1, NORM, 1'b0);
        do_reset("reset_mid_mem");
        do_reg("addu_recover", 6'h00, 6'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
